alu_arbiter: RTL and testbench

//  Shares one combinational ALU between N_REQ requesters (e.g. main datapath, address-gen, CSR path).

---
 rtl/alu_arbiter_pkg.sv | 45 ++++
 rtl/alu_arbiter_rr_arbiter.sv | 34 +++
 rtl/alu_arbiter.sv | 77 +++++++
 tb/tb_alu_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings, request record, arbiter FSM states and the combinational ALU function.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } arb_state_e;

  // Unknown op codes yield zero so a bad op never corrupts the handshake.
  function automatic logic [31:0] alu_calc(input alu_req_t r);
    logic [31:0] res;
    case (r.op)
      ALU_ADD:  res = r.a + r.b;
      ALU_SUB:  res = r.a - r.b;
      ALU_AND:  res = r.a & r.b;
      ALU_OR:   res = r.a | r.b;
      ALU_XOR:  res = r.a ^ r.b;
      ALU_SLT:  res = {31'b0, $signed(r.a) < $signed(r.b)};
      ALU_SLTU: res = {31'b0, r.a < r.b};
      ALU_SLL:  res = r.a << r.b[4:0];
      ALU_SRL:  res = r.a >> r.b[4:0];
      ALU_SRA:  res = $unsigned($signed(r.a) >>> r.b[4:0]);
      default:  res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Two passes: positions >= ptr first, then the wrapped-around low positions.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// One shared ALU behind a round-robin arbiter; result lands in a single-entry slot one cycle after the grant.
// Grants stall while the slot is full and not draining; a draining slot can be reloaded the same cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ-1:0][3:0]  i_req_op,
  input  logic [N_REQ-1:0][31:0] i_req_a,
  input  logic [N_REQ-1:0][31:0] i_req_b,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic [ID_W-1:0]        o_rsp_id,
  input  logic                   i_rsp_ready
);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [N_REQ-1:0] req_elig;
  logic [N_REQ-1:0] grant;
  logic             any_grant;
  logic             slot_free;
  alu_req_t         alu_in;
  logic [31:0]      alu_out;

  // Reset gates the requests so no ready leaks out while rst_n is low.
  assign slot_free = (state == S_EMPTY) | i_rsp_ready;
  assign req_elig  = (slot_free && i_rst_n) ? i_req_valid : '0;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req   (req_elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any_grant)
  );

  assign o_req_ready = grant;
  assign alu_in      = '{op: i_req_op[win], a: i_req_a[win], b: i_req_b[win]};
  assign alu_out     = alu_calc(alu_in);
  assign o_rsp_valid = (state == S_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (any_grant) state_nxt = S_FULL;
      S_FULL:  if (i_rsp_ready && !any_grant) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_EMPTY;
      ptr        <= '0;
      o_rsp_data <= 32'd0;
      o_rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (any_grant) begin
        o_rsp_data <= alu_out;
        o_rsp_id   <= win;
        ptr        <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed vector bench for alu_arbiter (N_REQ=2): table of per-cycle stimulus/expectations plus corner sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N_REQ = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][3:0]  req_op;
  logic [N_REQ-1:0][31:0] req_a;
  logic [N_REQ-1:0][31:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [31:0]            rsp_data;
  logic [0:0]             rsp_id;
  logic                   rsp_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int p1_wait = 0;
  logic fair_en = 1'b0;

  alu_arbiter #(.N_REQ(N_REQ), .ID_W(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .i_rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic        rr;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_id;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(logic [1:0] vld, logic [3:0] op0, logic [31:0] a0, logic [31:0] b0,
                              logic [3:0] op1, logic [31:0] a1, logic [31:0] b1, logic rr,
                              logic [1:0] e_rdy, logic e_vld, logic [31:0] e_dat, logic e_id);
    vec_t v;
    v.vld = vld; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_id = e_id;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are compared at the following negedge.
  task automatic apply(input vec_t v, input string nm);
    req_valid = v.vld;
    req_op[0] = v.op0; req_a[0] = v.a0; req_b[0] = v.b0;
    req_op[1] = v.op1; req_a[1] = v.a1; req_b[1] = v.b1;
    rsp_ready = v.rr;
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'(v.e_rdy));
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(v.e_vld));
    chk({nm, " rsp_data"}, rsp_data, v.e_dat);
    chk({nm, " rsp_id"}, 32'(rsp_id), 32'(v.e_id));
    @(posedge clk);
    #1;
  endtask

  // Port 1 must never see N_REQ consecutive grants go elsewhere while it waits.
  always @(negedge clk) begin
    if (fair_en && (req_ready != 2'b00)) begin
      n_cmp++;
      if ((req_ready & ~req_valid) != 2'b00) begin
        n_bad++;
        $display("FAIL fair ready_to_idle: ready %b, valid %b", req_ready, req_valid);
      end else if (req_valid[1]) begin
        if (req_ready[1]) p1_wait = 0;
        else begin
          p1_wait++;
          if (p1_wait >= N_REQ) begin
            n_bad++;
            $display("FAIL fairness: port1 waited %0d grants, limit %0d", p1_wait, N_REQ - 1);
          end
        end
      end
    end
  end

  initial begin
    vt[0]  = mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    vt[1]  = mk(2'b01, ALU_ADD, 5, 7, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0);
    vt[2]  = mk(2'b10, ALU_ADD, 0, 0, ALU_ADD, 1, 1, 1'b1, 2'b10, 1'b1, 32'd12, 1'b0);
    vt[3]  = mk(2'b11, ALU_SUB, 10, 3, ALU_ADD, 100, 200, 1'b1, 2'b01, 1'b1, 32'd2, 1'b1);
    vt[4]  = mk(2'b11, ALU_SUB, 10, 3, ALU_ADD, 100, 200, 1'b1, 2'b10, 1'b1, 32'd7, 1'b0);
    vt[5]  = mk(2'b11, ALU_SUB, 10, 3, ALU_ADD, 100, 200, 1'b1, 2'b01, 1'b1, 32'd300, 1'b1);
    vt[6]  = mk(2'b11, ALU_SUB, 10, 3, ALU_ADD, 100, 200, 1'b1, 2'b10, 1'b1, 32'd7, 1'b0);
    vt[7]  = mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b1, 32'd300, 1'b1);
    vt[8]  = mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b0, 32'd300, 1'b1);
    vt[9]  = mk(2'b01, ALU_SRA, 32'h8000_0000, 4, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b0, 32'd300, 1'b1);
    vt[10] = mk(2'b01, ALU_SLTU, 1, 32'hFFFF_FFFF, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'hF800_0000, 1'b0);
    vt[11] = mk(2'b01, ALU_SLT, 1, 32'hFFFF_FFFF, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'd1, 1'b0);
    vt[12] = mk(2'b01, ALU_XOR, 32'hF0F0, 32'h0FF0, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'd0, 1'b0);
    vt[13] = mk(2'b01, 4'hF, 5, 5, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'h0000_FF00, 1'b0);
    vt[14] = mk(2'b01, ALU_SLL, 1, 31, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'd0, 1'b0);
    vt[15] = mk(2'b01, ALU_SRL, 32'h8000_0000, 36, ALU_ADD, 0, 0, 1'b1, 2'b01, 1'b1, 32'h8000_0000, 1'b0);
    vt[16] = mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b1, 32'h0800_0000, 1'b0);
    vt[17] = mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b0, 2'b00, 1'b0, 32'h0800_0000, 1'b0);

    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #3;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Backpressure: slot full and stalled for three cycles, then drain plus new grant together.
    apply(mk(2'b10, ALU_OR, 32'h100, 32'h001, ALU_AND, 32'hFF, 32'h0F, 1'b0, 2'b10, 1'b0, 32'h0800_0000, 1'b0), "bp0");
    for (int i = 1; i <= 3; i++)
      apply(mk(2'b11, ALU_OR, 32'h100, 32'h001, ALU_AND, 32'hFF, 32'h0F, 1'b0, 2'b00, 1'b1, 32'h0F, 1'b1),
            $sformatf("bp%0d", i));
    apply(mk(2'b11, ALU_OR, 32'h100, 32'h001, ALU_AND, 32'hFF, 32'h0F, 1'b1, 2'b01, 1'b1, 32'h0F, 1'b1), "bp4");
    apply(mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b1, 32'h101, 1'b0), "bp5");

    // Reset while the slot is full and both ports request.
    apply(mk(2'b01, ALU_ADD, 2, 3, ALU_ADD, 4, 4, 1'b0, 2'b01, 1'b0, 32'h101, 1'b0), "rs0");
    apply(mk(2'b11, ALU_ADD, 2, 3, ALU_ADD, 4, 4, 1'b0, 2'b00, 1'b1, 32'd5, 1'b0), "rs1");
    rst_n = 1'b0;
    req_a[0] = 20; req_b[0] = 22;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd0);
    chk("midrst rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1;
    apply(mk(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 1'b1, 2'b00, 1'b1, 32'd42, 1'b0), "rs2");

    // Fairness: port 1 always valid, port 0 toggling, consumer always ready.
    fair_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = {1'b1, 1'(i % 2)};
      req_op[0] = ALU_ADD; req_a[0] = i; req_b[0] = 1;
      req_op[1] = ALU_SUB; req_a[1] = 100; req_b[1] = i;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    fair_en = 1'b0;
    req_valid = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
